// File: rtl/sprite_pkg.sv
// Shared screen geometry, blitter state encoding and frame-buffer addressing
// for the sprite blitter.
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } blit_state_t;

    // Linear frame-buffer index for an on-screen pixel (x < 640, y < 480).
    function automatic logic [18:0] fb_index(input logic [10:0] x, input logic [10:0] y);
        logic [18:0] y_ext;
        y_ext = 19'(y);
        return 19'(y_ext * 19'(SCREEN_W)) + 19'(x);
    endfunction

endpackage

// File: rtl/sprite_blitter.sv
// Streams a sprite ROM in raster order into the frame buffer, dropping
// key-coloured and off-screen pixels, with a three-stage issue/data/write pipe.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int          SPRITE_W  = 40,
    parameter int          SPRITE_H  = 52,
    parameter logic [23:0] KEY_COLOR = 24'hffffff
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic [11:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [23:0] fb_data,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done
);

    localparam int          PIXELS    = SPRITE_W * SPRITE_H;
    localparam int          COL_W     = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int          ROW_W     = (SPRITE_H > 1) ? $clog2(SPRITE_H + 1) : 1;
    localparam logic [11:0] LAST_ADDR = 12'(PIXELS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);

    blit_state_t state_reg, state_next;

    logic [9:0]       pos_x_reg, pos_y_reg;
    logic [COL_W-1:0] a_col_reg;
    logic [ROW_W-1:0] a_row_reg;
    logic [11:0]      a_addr_reg;

    logic             b_valid_reg;
    logic [COL_W-1:0] b_col_reg;
    logic [ROW_W-1:0] b_row_reg;
    logic [11:0]      b_addr_reg;

    logic             fb_we_reg;
    logic [18:0]      fb_addr_reg;
    logic [23:0]      fb_data_reg;
    logic             stall_q_reg;

    logic             stall;
    logic             issue;
    logic             visible;
    logic [10:0]      sx, sy;

    assign stall = fb_we_reg & ~fb_ready;
    // The cycle a stall releases is spent re-presenting stage A's address,
    // because the ROM was showing stage B's pixel during the stall.
    assign issue = (state_reg == ST_RUN) & ~stall & ~stall_q_reg;

    assign sx = {1'b0, pos_x_reg} + 11'(b_col_reg);
    assign sy = {1'b0, pos_y_reg} + 11'(b_row_reg);
    assign visible = b_valid_reg && (rom_data != KEY_COLOR)
                  && (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));

    assign rom_addr = stall ? b_addr_reg : a_addr_reg;
    assign fb_we    = fb_we_reg;
    assign fb_addr  = fb_addr_reg;
    assign fb_data  = fb_data_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (issue && a_addr_reg == LAST_ADDR) state_next = ST_DRAIN;
            ST_DRAIN: if (!b_valid_reg && (!fb_we_reg || fb_ready)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg   <= ST_IDLE;
            stall_q_reg <= 1'b0;
            pos_x_reg   <= '0;
            pos_y_reg   <= '0;
            a_col_reg   <= '0;
            a_row_reg   <= '0;
            a_addr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            stall_q_reg <= stall;
            if (state_reg == ST_IDLE && start) begin
                pos_x_reg  <= pos_x;
                pos_y_reg  <= pos_y;
                a_col_reg  <= '0;
                a_row_reg  <= '0;
                a_addr_reg <= '0;
            end else if (issue) begin
                a_addr_reg <= a_addr_reg + 12'd1;
                if (a_col_reg == COL_LAST) begin
                    a_col_reg <= '0;
                    a_row_reg <= a_row_reg + ROW_W'(1);
                end else begin
                    a_col_reg <= a_col_reg + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            b_valid_reg <= 1'b0;
            b_col_reg   <= '0;
            b_row_reg   <= '0;
            b_addr_reg  <= '0;
            fb_we_reg   <= 1'b0;
            fb_addr_reg <= '0;
            fb_data_reg <= '0;
        end else if (!stall) begin
            b_valid_reg <= issue;
            if (issue) begin
                b_col_reg  <= a_col_reg;
                b_row_reg  <= a_row_reg;
                b_addr_reg <= a_addr_reg;
            end
            fb_we_reg <= visible;
            if (visible) begin
                fb_addr_reg <= fb_index(sx, sy);
                fb_data_reg <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench: a raster-order golden model fills a scoreboard queue,
// a negedge monitor pops it on every accepted frame-buffer write.
module tb_sprite_blitter;

    localparam int W = 40;
    localparam int H = 52;
    localparam int FULL_DONE = W * H + 3;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [11:0] rom_addr;
    logic [23:0] rom_data = '0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_ready = 1'b1;
    logic        busy;
    logic        done;

    sprite_blitter dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 Clk = ~Clk;

    logic [23:0] rom_mem [4096];
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    typedef struct packed {
        logic [18:0] a;
        logic [23:0] d;
    } wr_t;

    wr_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int ready_low_pct = 0;

    int cyc = 100000;
    int wr_cnt = 0;
    int first_wr_cyc = -1;
    int last_wr_cyc = -1;
    int done_cyc = -1;
    logic [18:0] first_wr_addr = '0;
    logic [18:0] last_wr_addr = '0;
    logic        hold_v = 1'b0;
    logic [18:0] hold_a = '0;
    logic [23:0] hold_d = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Golden model: every sprite pixel in raster order, kept if opaque and on screen.
    task automatic build_expected(input int px, input int py);
        wr_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int sx, sy;
                logic [23:0] colr;
                colr = rom_mem[r * W + c];
                sx = px + c;
                sy = py + r;
                if (colr != 24'hffffff && sx < 640 && sy < 480) begin
                    e.a = 19'(sy * 640 + sx);
                    e.d = colr;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // mode 0: all opaque, 1: first row transparent, 2: ~20% transparent
    task automatic fill_rom(input int mode);
        for (int i = 0; i < 4096; i++) begin
            logic [23:0] v;
            v = 24'($urandom) & 24'hfffffe;
            if (mode == 1 && i < W) v = 24'hffffff;
            if (mode == 2 && $urandom_range(99) < 20) v = 24'hffffff;
            rom_mem[i] = v;
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            fb_ready = ($urandom_range(99) >= ready_low_pct);
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                hold_v = 1'b0;
            end else begin
                cyc++;
                if (start && !busy) begin
                    cyc = 0;
                    wr_cnt = 0;
                    first_wr_cyc = -1;
                    done_cyc = -1;
                end
                if (cyc == 1) begin
                    check("busy_cycle1", 64'(busy), 64'd1);
                    check("rom_addr_cycle1", 64'(rom_addr), 64'd0);
                end
                if (hold_v)
                    check("stall_hold", 64'({fb_we, fb_addr, fb_data}), 64'({1'b1, hold_a, hold_d}));
                hold_v = fb_we && !fb_ready;
                hold_a = fb_addr;
                hold_d = fb_data;
                if (fb_we && fb_ready) begin
                    if (wr_cnt == 0) begin
                        first_wr_cyc = cyc;
                        first_wr_addr = fb_addr;
                    end
                    last_wr_cyc = cyc;
                    last_wr_addr = fb_addr;
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got addr %0d data %0h, expected none", fb_addr, fb_data);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("fb_write", 64'({fb_addr, fb_data}), 64'({e.a, e.d}));
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
                end
            end
        end
    end

    task automatic run_blit(input int px, input int py, input int low_pct,
                            input int exp_done, input bit poke);
        int n;
        build_expected(px, py);
        ready_low_pct = low_pct;
        @(posedge Clk);
        #1;
        pos_x = 10'(px);
        pos_y = 10'(py);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        pos_x = 10'($urandom);
        pos_y = 10'($urandom);
        n = 0;
        while (!done && n < 20000) begin
            @(posedge Clk);
            #1;
            start = poke && (n == 300);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL blit_timeout: got no done after %0d cycles, expected done", n);
            exp_q.delete();
        end else begin
            @(negedge Clk);
            #1;
            if (exp_done > 0) check("done_cycle", 64'(done_cyc), 64'(exp_done));
            @(negedge Clk);
            #1;
            check("busy_low_after_done", 64'({busy, done}), 64'd0);
        end
        $display("[TB] blit pos=(%0d,%0d) ready_low=%0d%% writes=%0d first_wr_cyc=%0d last_wr_cyc=%0d done_cyc=%0d",
                 px, py, low_pct, wr_cnt, first_wr_cyc, last_wr_cyc, done_cyc);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs", 64'({rom_addr, fb_we, fb_addr, fb_data, busy, done}), 64'd0);
        Reset_n = 1'b1;

        // Opaque sprite at the origin, full rate
        fill_rom(0);
        run_blit(0, 0, 0, FULL_DONE, 1'b0);
        check("opaque_write_count", 64'(wr_cnt), 64'(W * H));
        check("opaque_first_write_cycle", 64'(first_wr_cyc), 64'd3);
        check("opaque_last_write_cycle", 64'(last_wr_cyc), 64'(W * H + 2));

        // Transparent first row
        fill_rom(1);
        run_blit(100, 50, 0, FULL_DONE, 1'b0);
        check("keyrow_first_addr", 64'(first_wr_addr), 64'(51 * 640 + 100));
        check("keyrow_write_count", 64'(wr_cnt), 64'(W * (H - 1)));

        // Bottom-right clipping
        fill_rom(0);
        run_blit(620, 470, 0, FULL_DONE, 1'b0);
        check("clip_write_count", 64'(wr_cnt), 64'd200);
        check("clip_last_addr", 64'(last_wr_addr), 64'(479 * 640 + 639));

        // Random back-pressure, random positions, start pokes while busy
        for (int k = 0; k < 3; k++) begin
            fill_rom(2);
            run_blit(int'($urandom_range(700)), int'($urandom_range(520)), 30, 0, k != 1);
        end

        // Reset while a write is stalled in the output register
        fill_rom(0);
        build_expected(200, 200);
        ready_low_pct = 100;
        @(posedge Clk);
        #1;
        pos_x = 10'd200;
        pos_y = 10'd200;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!fb_we && n < 50) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("stalled_write_before_reset", 64'({fb_we, fb_ready}), 64'b10);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({rom_addr, fb_we, fb_addr, fb_data, busy, done}), 64'd0);
        exp_q.delete();
        ready_low_pct = 0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        $display("[TB] reset mid-blit applied after %0d stalled cycles", n);
        run_blit(0, 0, 0, FULL_DONE, 1'b0);
        check("restart_write_count", 64'(wr_cnt), 64'(W * H));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Reads a palette-decoded sprite ROM in raster order and writes the sprite's visible pixels into the 640x480 frame buffer at a requested screen position. It is the initiator for the sprite ROMs, such as the shield ROM: it drives the ROM's `read_address`, consumes its 24-bit `data_out` one cycle later, and skips transparent and off-screen pixels. It sits between game logic (issues `start` plus a position) and the frame-buffer write port.

## Interface
- `SPRITE_W`, 40: sprite width in pixels.
- `SPRITE_H`, 52: sprite height in pixels; `SPRITE_W*SPRITE_H` must be ≤ 4096.
- `KEY_COLOR`, 24'hffffff: ROM colour treated as transparent.
- `Clk` input 1: the only clock; all state is updated on its rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request; sampled only in IDLE.
- `pos_x` input 10: screen column of the sprite's top-left pixel; captured when `start` is accepted.
- `pos_y` input 10: screen row of the sprite's top-left pixel; captured when `start` is accepted.
- `rom_addr` output 12: ROM read address.
- `rom_data` input 24: ROM colour, valid one cycle after the address is presented.
- `fb_we` output 1: frame-buffer write valid.
- `fb_addr` output 19: frame-buffer address, `y*640 + x`.
- `fb_data` output 24: pixel colour.
- `fb_ready` input 1: frame buffer accepts a write when `fb_we & fb_ready`.
- `busy` output 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output 1: one-cycle pulse at the end of a blit.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when `start` is high. `pos_x` and `pos_y` are latched on that edge, and the column, row and address counters clear to 0.
- Pipeline stages:
  - A: address issue, tracking col, row and addr.
  - B: ROM data valid, carrying the delayed col and row plus a valid bit.
  - C: frame-buffer output register.
- Raster order: addr increments by 1 per issue. col wraps at `SPRITE_W-1` to 0, and row increments on that wrap.
- Screen coordinates in stage B: `sx = pos_x + col` and `sy = pos_y + row`, both computed at 11 bits with no wrap.
- A stage-B pixel is visible iff `rom_data != KEY_COLOR`, `sx < 640` and `sy < 480`.
  - Visible pixels load C with `fb_addr = sy*640 + sx` and `fb_data = rom_data`.
  - Invisible pixels are dropped with no write.
- Stall: C is valid and `fb_ready` is 0.
  - Stages A and B freeze.
  - `rom_addr` is driven with stage B's address, so `rom_data` keeps presenting stage B's pixel.
- Stall release: the first cycle with `fb_ready=1` does the following:
  - C accepts.
  - Stage B moves to C, or is dropped if invisible.
  - `rom_addr` re-presents stage A's address, and stage B is invalid for one cycle.
  - Each stall release therefore costs exactly one bubble.
- RUN -> DRAIN once the last address (`SPRITE_W*SPRITE_H-1`) has been issued.
- DRAIN -> DONE when stages B and C are both empty. DONE lasts one cycle with `done=1`, then the block returns to IDLE.
- `start` while `busy` is ignored.
- Asynchronous reset at any point forces IDLE, clears all valid bits, and abandons the blit. A write pending in C is abandoned and never retried.

## Timing
- Reset values: `rom_addr=0`, `fb_we=0`, `fb_addr=0`, `fb_data=0`, `busy=0`, `done=0`.
- `start` sampled at edge 0:
  - cycle 1: `rom_addr=0`, and `busy` goes high.
  - cycle 2: `rom_data` holds pixel 0.
  - cycle 3: `fb_we` is asserted if pixel 0 is visible.
- With `fb_ready` held at 1 the block sustains one pixel per cycle. The last address issues in cycle `SPRITE_W*SPRITE_H`, and `done` pulses in cycle `SPRITE_W*SPRITE_H + 3`.
- `fb_we`, `fb_addr` and `fb_data` are registered and stay stable while `fb_we & !fb_ready`.
- `rom_addr` is combinational from the stage registers and the stall condition. The ROM registers it internally.

## Structure
- `sprite_pkg` holds:
  - the screen constants `SCREEN_W=640` and `SCREEN_H=480`,
  - the state enum `blit_state_t`,
  - the helper function `fb_index(x, y)`.
- A single module is sufficient. The visibility and clip test is kept inside it and not split out.

## Test plan
- Opaque 40x52 sprite at (0,0) with `fb_ready=1`:
  - 2080 writes, addresses `row*640+col`, one per cycle.
  - `done` in cycle 2083, and `busy` low in the following cycle.
- Sprite whose ROM has `KEY_COLOR` at addresses 0..39, at (100,50): no writes for row 0, and the first write is at `fb_addr=51*640+100`.
- Clipping at (620,470): only `col<20`, `row<10` are written, giving 200 writes, and the last `fb_addr` is `479*640+639`.
- Random `fb_ready` gaps (about 30% low):
  - written pixels match the golden model exactly, in order, with no duplicates or losses.
  - outputs stay stable during every stall.
- `start` pulses while `busy` are ignored. A second `start` after `done` runs a full blit again.
- `Reset_n` asserted mid-blit with `fb_we` high and `fb_ready` low: all outputs go to 0 immediately, and the next `start` restarts from address 0.
